// File: rtl/sobel_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_frame_ctrl
//
// Frame sequencer for the sobelBlock edge-detection datapath. Walks an 8-bpp
// frame in a byte-addressed source memory, builds every 3x3 window (reusing
// two of the three columns when the window slides right), runs sobelBlock
// on it, writes the result at the window centre in the destination memory,
// and finally zero-fills the destination border.
//
// Ports
//   clk, n_rst                    clock (rising edge), async active-low reset
//   start                         one-cycle frame request, honoured in IDLE only
//   num_rows, num_cols            frame dimensions, latched on accepted start
//   src_base, dst_base            memory base addresses, latched on accepted start
//   rd_en, rd_addr, rd_data       source read port, data one cycle after rd_en
//   wr_en, wr_addr, wr_data       destination write port, one byte per cycle
//   sobel_enable, image_buffer    sobelBlock start pulse and 3x3 window
//   sobel_done, sobel_pixel       sobelBlock completion flag and result
//   busy, frame_done, err         frame status
// -----------------------------------------------------------------------------
module sobel_frame_ctrl #(
  parameter int ADDR_W = 20,
  parameter int DIM_W  = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  num_rows,
  input  logic [DIM_W-1:0]  num_cols,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              sobel_enable,
  output logic [71:0]       image_buffer,
  input  logic              sobel_done,
  input  logic [7:0]        sobel_pixel,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPTURE, S_FIRE, S_WAIT_DONE, S_WRITE, S_BORDER, S_FINISH
  } state_t;

  // Border walk: top row, bottom row, then left/right pixel of each inner row.
  typedef enum logic [1:0] {B_TOP, B_BOT, B_SIDE} border_t;

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  rows_q, cols_q, row_q, col_q, b_cnt_q;
  logic [ADDR_W-1:0] src_q, dst_q, row_off_q, b_off_q;
  logic [1:0]        i_cnt_q, j_cnt_q;
  logic              cap_vld_q;
  logic [3:0]        cap_slot_q;
  logic [7:0]        pix_q;
  logic              err_q;
  border_t           b_phase_q;
  logic              b_right_q;

  logic              dims_ok, fetch_last, col_more, row_more, border_last;
  logic [ADDR_W-1:0] cols_a, row_term, rd_ptr, win_wr_ptr, bd_ptr;

  assign dims_ok     = (num_rows >= DIM_W'(3)) && (num_cols >= DIM_W'(3));
  assign fetch_last  = (i_cnt_q == 2'd2) && (j_cnt_q == 2'd2);
  assign col_more    = col_q < (cols_q - DIM_W'(3));
  assign row_more    = row_q < (rows_q - DIM_W'(3));
  assign border_last = (b_phase_q == B_SIDE) && b_right_q &&
                       (b_cnt_q == rows_q - DIM_W'(2));

  // row_off_q holds r*num_cols, so window addresses only need adds and a shift.
  assign cols_a     = ADDR_W'(cols_q);
  assign row_term   = (i_cnt_q == 2'd0) ? '0 :
                      (i_cnt_q == 2'd1) ? cols_a : (cols_a << 1);
  assign rd_ptr     = src_q + row_off_q + ADDR_W'(col_q) + row_term + ADDR_W'(j_cnt_q);
  assign win_wr_ptr = dst_q + row_off_q + cols_a + ADDR_W'(col_q) + ADDR_W'(1);
  assign bd_ptr     = dst_q + b_off_q;

  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: every clocked block uses non-blocking assignments so all flops see
    // the pre-edge values of each other, regardless of evaluation order.
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d      = state_q;
    rd_en        = 1'b0;
    rd_addr      = '0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    sobel_enable = 1'b0;
    busy         = 1'b1;
    frame_done   = 1'b0;
    err          = err_q;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = dims_ok ? S_FETCH : S_FINISH;
      end
      S_FETCH: begin
        rd_en   = 1'b1;
        rd_addr = rd_ptr;
        if (fetch_last) state_d = S_CAPTURE;
      end
      S_CAPTURE: state_d = S_FIRE;
      S_FIRE: begin
        sobel_enable = 1'b1;
        state_d      = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (sobel_done) state_d = S_WRITE;
      S_WRITE: begin
        wr_en   = 1'b1;
        wr_addr = win_wr_ptr;
        wr_data = pix_q;
        state_d = (col_more || row_more) ? S_FETCH : S_BORDER;
      end
      S_BORDER: begin
        wr_en   = 1'b1;
        wr_addr = bd_ptr;
        if (border_last) state_d = S_FINISH;
      end
      S_FINISH: begin
        busy       = 1'b0;
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rows_q     <= '0;
      cols_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      b_cnt_q    <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      row_off_q  <= '0;
      b_off_q    <= '0;
      i_cnt_q    <= '0;
      j_cnt_q    <= '0;
      cap_vld_q  <= 1'b0;
      cap_slot_q <= '0;
      pix_q      <= '0;
      err_q      <= 1'b0;
      b_phase_q  <= B_TOP;
      b_right_q  <= 1'b0;
    end else begin
      // Remember which window slot the byte returning next cycle belongs to.
      cap_vld_q  <= (state_q == S_FETCH);
      cap_slot_q <= 4'({i_cnt_q, 1'b0}) + 4'(i_cnt_q) + 4'(j_cnt_q);
      case (state_q)
        S_IDLE: if (start) begin
          rows_q    <= num_rows;
          cols_q    <= num_cols;
          src_q     <= src_base;
          dst_q     <= dst_base;
          err_q     <= !dims_ok;
          row_q     <= '0;
          col_q     <= '0;
          row_off_q <= '0;
          i_cnt_q   <= '0;
          j_cnt_q   <= '0;
        end
        S_FETCH: begin
          // c=0 walks all nine slots; c>0 only refills column j=2.
          if ((col_q == '0) && (j_cnt_q != 2'd2)) begin
            j_cnt_q <= j_cnt_q + 2'd1;
          end else begin
            i_cnt_q <= i_cnt_q + 2'd1;
            if (col_q == '0) j_cnt_q <= '0;
          end
        end
        S_WAIT_DONE: if (sobel_done) pix_q <= sobel_pixel;
        S_WRITE: begin
          i_cnt_q <= '0;
          if (col_more) begin
            col_q   <= col_q + DIM_W'(1);
            j_cnt_q <= 2'd2;
          end else begin
            col_q     <= '0;
            j_cnt_q   <= '0;
            row_q     <= row_q + DIM_W'(1);
            row_off_q <= row_off_q + cols_a;
            b_phase_q <= B_TOP;
            b_off_q   <= '0;
            b_cnt_q   <= '0;
            b_right_q <= 1'b0;
          end
        end
        S_BORDER: begin
          case (b_phase_q)
            B_TOP, B_BOT: begin
              if (b_cnt_q == cols_q - DIM_W'(1)) begin
                b_cnt_q <= (b_phase_q == B_TOP) ? '0 : DIM_W'(1);
                // row_off_q is (R-2)*C here, so + C lands on the bottom row.
                b_off_q   <= (b_phase_q == B_TOP) ? row_off_q + cols_a : cols_a;
                b_phase_q <= (b_phase_q == B_TOP) ? B_BOT : B_SIDE;
              end else begin
                b_cnt_q <= b_cnt_q + DIM_W'(1);
                b_off_q <= b_off_q + ADDR_W'(1);
              end
            end
            default: begin
              b_right_q <= !b_right_q;
              if (!b_right_q) begin
                b_off_q <= b_off_q + cols_a - ADDR_W'(1);
              end else begin
                // Right edge of row i to left edge of row i+1 is one byte.
                b_off_q <= b_off_q + ADDR_W'(1);
                b_cnt_q <= b_cnt_q + DIM_W'(1);
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: the window is a small flop array driven straight to a port with a
    // defined reset value, so it is reset; a RAM-style array would not be.
    if (!n_rst) begin
      image_buffer <= '0;
    end else if (cap_vld_q) begin
      image_buffer[{cap_slot_q, 3'b000} +: 8] <= rd_data;
    end else if ((state_q == S_FETCH) && (col_q != '0) && (i_cnt_q == 2'd0)) begin
      for (int i = 0; i < 3; i++) begin
        image_buffer[24*i +: 8]     <= image_buffer[24*i + 8 +: 8];
        image_buffer[24*i + 8 +: 8] <= image_buffer[24*i + 16 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sobel_frame_ctrl
//
// Self-checking bench for sobel_frame_ctrl. A behavioural model computes, per
// frame, the full ordered list of source reads, the expected 3x3 window at
// each FIRE, and the ordered destination writes (interior then border) using
// plain row*cols arithmetic. A source-memory model and a sobelBlock model
// (random result, configurable latency, optional stray done pulses) drive the
// DUT inputs; a monitor on the falling edge compares everything.
// -----------------------------------------------------------------------------
module tb_sobel_frame_ctrl;

  localparam int AW = 20;
  localparam int DW = 16;

  typedef struct { logic [AW-1:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic [71:0] win; int fire_off; } win_t;

  logic          tb_clk;
  logic          n_rst;
  logic          start;
  logic [DW-1:0] num_rows, num_cols;
  logic [AW-1:0] src_base, dst_base;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          sobel_enable;
  logic [71:0]   image_buffer;
  logic          sobel_done;
  logic [7:0]    sobel_pixel;
  logic          busy, frame_done, err;

  sobel_frame_ctrl #(.ADDR_W(AW), .DIM_W(DW)) dut (
    .clk(tb_clk), .n_rst(n_rst), .start(start),
    .num_rows(num_rows), .num_cols(num_cols),
    .src_base(src_base), .dst_base(dst_base),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sobel_enable(sobel_enable), .image_buffer(image_buffer),
    .sobel_done(sobel_done), .sobel_pixel(sobel_pixel),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  // Model state
  logic [7:0]    mem [4096];
  logic [AW-1:0] rd_q [$];
  wr_t           wr_q [$];
  win_t          win_q [$];
  logic [7:0]    spix_q [$];

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;

  bit            rd_pend = 0;
  logic [AW-1:0] rd_pend_addr = '0;
  int            sob_cnt = 0;
  logic [7:0]    cur_pix = '0;
  bit            done_real = 0;
  bit            spur_pend = 0;
  bit            spur_en = 0;
  int            dly_fix = 0;
  bit            waiting = 0;
  logic [71:0]   ib_hold = '0;
  bit            fetching = 0;
  int            first_rd_cyc = 0;
  int            last_wr_cyc = 0;
  bit            fd_expect = 0;
  bit            expect_wr = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial begin
    tb_clk = 1'b0;
    forever #5 tb_clk = ~tb_clk;
  end

  initial forever begin
    @(posedge tb_clk);
    cyc++;
  end

  // Source memory and sobelBlock models: inputs change 1 time unit after the edge.
  initial begin
    rd_data = '0; sobel_done = 1'b0; sobel_pixel = '0;
    forever begin
      @(posedge tb_clk); #1;
      rd_data     = rd_pend ? mem[rd_pend_addr[11:0]] : 8'($urandom);
      sobel_done  = 1'b0;
      sobel_pixel = 8'($urandom);
      done_real   = 0;
      if (sob_cnt > 0) begin
        sob_cnt--;
        if (sob_cnt == 0) begin
          sobel_done  = 1'b1;
          sobel_pixel = cur_pix;
          done_real   = 1;
        end
      end else if (spur_pend) begin
        sobel_done = 1'b1;
        spur_pend  = 0;
      end
    end
  end

  // Monitor
  initial forever begin
    @(negedge tb_clk);
    if (n_rst) begin
      if (expect_wr) begin
        check("wr_after_done", 72'(wr_en), 72'd1);
        expect_wr = 0;
      end
      if (rd_en) begin
        if (!fetching) begin
          fetching = 1;
          first_rd_cyc = cyc;
        end
        if (rd_q.size() == 0) check("rd_extra", 72'(rd_en), 72'd0);
        else check("rd_addr", 72'(rd_addr), 72'(rd_q.pop_front()));
        rd_pend = 1;
        rd_pend_addr = rd_addr;
        if (spur_en && sob_cnt == 0 && $urandom_range(3) == 0) spur_pend = 1;
      end else begin
        rd_pend = 0;
      end
      if (sobel_enable) begin
        if (win_q.size() == 0) begin
          check("fire_extra", 72'(sobel_enable), 72'd0);
        end else begin
          win_t w;
          w = win_q.pop_front();
          check("window", image_buffer, w.win);
          check("fire_time", 72'(cyc - first_rd_cyc), 72'(w.fire_off));
        end
        fetching = 0;
        waiting  = 1;
        ib_hold  = image_buffer;
        cur_pix  = (spix_q.size() != 0) ? spix_q.pop_front() : 8'h00;
        sob_cnt  = (dly_fix > 0) ? dly_fix : int'($urandom_range(6, 1));
      end else if (waiting) begin
        check("ib_stable", image_buffer, ib_hold);
        if (done_real) begin
          waiting   = 0;
          expect_wr = 1;
        end
      end
      if (wr_en) begin
        if (wr_q.size() == 0) begin
          check("wr_extra", 72'(wr_en), 72'd0);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          check("wr_addr", 72'(wr_addr), 72'(e.addr));
          check("wr_data", 72'(wr_data), 72'(e.data));
        end
        last_wr_cyc = cyc;
      end
      if (frame_done && fd_expect) begin
        check("fd_gap", 72'(cyc - last_wr_cyc), 72'd1);
        check("fd_busy", 72'(busy), 72'd0);
        fd_expect = 0;
      end
    end else begin
      rd_pend = 0; fetching = 0; waiting = 0; expect_wr = 0;
    end
  end

  // Reference model: fills the source frame and lists every expected event.
  task automatic build_model(input int R, input int C, input logic [AW-1:0] src,
                             input logic [AW-1:0] dst, input int pat, input bit zero_pix);
    logic [AW-1:0] a;
    win_t          w;
    wr_t           e;
    logic [7:0]    px;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        a = src + AW'(r * C + c);
        mem[a[11:0]] = (pat == 1) ? 8'h40 : (pat == 2) ? 8'(10 * r + c) : 8'($urandom);
      end
    for (int r = 0; r <= R - 3; r++)
      for (int c = 0; c <= C - 3; c++) begin
        for (int i = 0; i < 3; i++) begin
          if (c == 0) for (int j = 0; j < 3; j++) rd_q.push_back(src + AW'((r + i) * C + j));
          else rd_q.push_back(src + AW'((r + i) * C + c + 2));
          for (int j = 0; j < 3; j++) begin
            a = src + AW'((r + i) * C + c + j);
            w.win[8 * (3 * i + j) +: 8] = mem[a[11:0]];
          end
        end
        w.fire_off = (c == 0) ? 10 : 4;
        win_q.push_back(w);
        px = zero_pix ? 8'h00 : 8'($urandom);
        spix_q.push_back(px);
        e.addr = dst + AW'((r + 1) * C + c + 1);
        e.data = px;
        wr_q.push_back(e);
      end
    e.data = 8'h00;
    for (int c = 0; c < C; c++) begin e.addr = dst + AW'(c); wr_q.push_back(e); end
    for (int c = 0; c < C; c++) begin e.addr = dst + AW'((R - 1) * C + c); wr_q.push_back(e); end
    for (int r = 1; r <= R - 2; r++) begin
      e.addr = dst + AW'(r * C);         wr_q.push_back(e);
      e.addr = dst + AW'(r * C + C - 1); wr_q.push_back(e);
    end
  endtask

  task automatic start_frame(input int R, input int C, input logic [AW-1:0] src,
                             input logic [AW-1:0] dst);
    @(posedge tb_clk); #1;
    num_rows = DW'(R); num_cols = DW'(C); src_base = src; dst_base = dst;
    start = 1'b1;
    fd_expect = 1;
    @(negedge tb_clk);
    check("busy_c0", 72'(busy), 72'd0);
    @(posedge tb_clk); #1;
    start = 1'b0;
    @(negedge tb_clk);
    check("first_rd", 72'(rd_en), 72'd1);
    check("busy_c1", 72'(busy), 72'd1);
    check("err_clear", 72'(err), 72'd0);
  endtask

  task automatic wait_frame(input bit noise);
    bit got = 0;
    for (int k = 0; k < 4000; k++) begin
      @(posedge tb_clk); #1;
      start = noise && ($urandom_range(5) == 0);
      @(negedge tb_clk);
      if (frame_done) begin got = 1; break; end
    end
    start = 1'b0;
    check("frame_done_seen", 72'(got), 72'd1);
    check("rd_left", 72'(rd_q.size()), 72'd0);
    check("wr_left", 72'(wr_q.size()), 72'd0);
    check("win_left", 72'(win_q.size()), 72'd0);
  endtask

  task automatic run_frame(input int R, input int C, input logic [AW-1:0] src,
                           input logic [AW-1:0] dst, input int pat, input int dly,
                           input bit spur, input bit noise, input bit zero_pix);
    build_model(R, C, src, dst, pat, zero_pix);
    dly_fix = dly;
    spur_en = spur;
    start_frame(R, C, src, dst);
    wait_frame(noise);
    spur_en = 0;
  endtask

  task automatic run_bad(input int R, input int C);
    @(posedge tb_clk); #1;
    num_rows = DW'(R); num_cols = DW'(C); src_base = '0; dst_base = '0;
    start = 1'b1;
    fd_expect = 0;
    @(negedge tb_clk);
    @(posedge tb_clk); #1;
    start = 1'b0;
    @(negedge tb_clk);
    check("bad_err", 72'(err), 72'd1);
    check("bad_fd", 72'(frame_done), 72'd1);
    check("bad_busy", 72'(busy), 72'd0);
    repeat (3) begin
      @(negedge tb_clk);
      check("bad_fd_once", 72'(frame_done), 72'd0);
      check("bad_err_hold", 72'(err), 72'd1);
    end
  endtask

  task automatic reset_in_wait();
    bit seen = 0;
    build_model(4, 4, 20'd512, 20'd1500, 0, 0);
    dly_fix = 40;
    start_frame(4, 4, 20'd512, 20'd1500);
    for (int k = 0; k < 200; k++) begin
      @(negedge tb_clk);
      if (sobel_enable) begin seen = 1; break; end
    end
    check("rst_fire_seen", 72'(seen), 72'd1);
    repeat (3) @(negedge tb_clk);
    #2;
    n_rst = 1'b0;
    rd_q.delete(); wr_q.delete(); win_q.delete(); spix_q.delete();
    sob_cnt = 0; spur_pend = 0; fd_expect = 0;
    #1;
    check("arst_rd_en", 72'(rd_en), 72'd0);
    check("arst_wr_en", 72'(wr_en), 72'd0);
    check("arst_sob_en", 72'(sobel_enable), 72'd0);
    check("arst_busy", 72'(busy), 72'd0);
    check("arst_fd", 72'(frame_done), 72'd0);
    check("arst_err", 72'(err), 72'd0);
    check("arst_rd_addr", 72'(rd_addr), 72'd0);
    check("arst_wr_addr", 72'(wr_addr), 72'd0);
    check("arst_wr_data", 72'(wr_data), 72'd0);
    check("arst_ib", image_buffer, 72'd0);
    repeat (3) @(negedge tb_clk);
    @(posedge tb_clk); #1;
    n_rst = 1'b1;
    repeat (20) begin
      @(negedge tb_clk);
      check("post_rst_wr", 72'(wr_en), 72'd0);
      check("post_rst_fd", 72'(frame_done), 72'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_rst = 1'b0; start = 1'b0;
    num_rows = '0; num_cols = '0; src_base = '0; dst_base = '0;
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    repeat (3) @(posedge tb_clk);
    @(negedge tb_clk);
    check("rst_rd_en", 72'(rd_en), 72'd0);
    check("rst_wr_en", 72'(wr_en), 72'd0);
    check("rst_sob_en", 72'(sobel_enable), 72'd0);
    check("rst_busy", 72'(busy), 72'd0);
    check("rst_fd", 72'(frame_done), 72'd0);
    check("rst_err", 72'(err), 72'd0);
    check("rst_rd_addr", 72'(rd_addr), 72'd0);
    check("rst_wr_addr", 72'(wr_addr), 72'd0);
    check("rst_wr_data", 72'(wr_data), 72'd0);
    check("rst_ib", image_buffer, 72'd0);
    @(posedge tb_clk); #1;
    n_rst = 1'b1;

    // 3x3 flat frame, sobelBlock answers 0 after 3 cycles.
    run_frame(3, 3, 20'd40, 20'd100, 1, 3, 0, 0, 1);
    // 4x5 ramp, destination at 0: interior writes land at 6,7,8,11,12,13.
    run_frame(4, 5, 20'd200, 20'd0, 2, 0, 0, 0, 0);
    // Slow sobelBlock with stray done pulses during fetch.
    run_frame(5, 6, 20'd300, 20'd2000, 0, 7, 1, 0, 0);
    // Rejected dimensions, then a valid frame clears err.
    run_bad(5, 2);
    run_bad(2, 7);
    run_frame(3, 4, 20'd700, 20'd900, 0, 0, 0, 0, 0);
    // start pulses while busy are ignored.
    run_frame(5, 5, 20'd1000, 20'd3000, 0, 0, 0, 1, 0);
    // Address arithmetic wraps at 2^ADDR_W.
    run_frame(4, 6, 20'hFFFF0, 20'hFFFFA, 0, 2, 0, 0, 0);
    // Reset during WAIT_DONE, then a clean 3x3 frame.
    reset_in_wait();
    run_frame(3, 3, 20'd60, 20'd150, 0, 0, 0, 0, 0);
    // Randomised frames.
    for (int n = 0; n < 6; n++)
      run_frame(int'($urandom_range(8, 3)), int'($urandom_range(10, 3)),
                AW'($urandom_range(3000)), AW'($urandom), 0, 0,
                1'($urandom_range(1)), 1'($urandom_range(1)), 0);

    repeat (5) @(negedge tb_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
